// File: rtl/set_ctrl_pkg.sv
// Shared types and constants for the clock time-setting controller (set_ctrl).
package set_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOUR = 2'd1,
        MIN  = 2'd2,
        SEC  = 2'd3
    } state_t;

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_HOUR = 3'b100;
    localparam logic [2:0] SEL_MIN  = 3'b010;
    localparam logic [2:0] SEL_SEC  = 3'b001;

    function automatic logic [2:0] sel_of(input state_t s);
        case (s)
            HOUR:    return SEL_HOUR;
            MIN:     return SEL_MIN;
            SEC:     return SEL_SEC;
            default: return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/set_ctrl_cyc_cnt.sv
// Terminal-count counter 0..N-1 with synchronous clear; end_cnt flags the wrap cycle.
module cyc_cnt #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic end_cnt
);

    localparam int W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt;

    // NOTE: sequential state is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    // A clear in the same cycle suppresses the terminal event.
    assign end_cnt = en && !clr && (cnt == LAST);

endmodule

// File: rtl/set_ctrl.sv
// Time-setting controller: RUN -> HOUR -> MIN -> SEC -> RUN with field blink.
// Define SET_CTRL_TIMEOUT_EN to return to RUN after T_TIMEOUT idle cycles in a set state.
module set_ctrl
    import set_ctrl_pkg::*;
#(
    parameter int T_BLINK   = 20,
    parameter int T_TIMEOUT = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_vld,
    input  logic       up_vld,
    input  logic       down_vld,
    output logic [2:0] sel,
    output logic       inc,
    output logic       dec,
    output logic       run_en,
    output logic       show,
    output logic       done
);

    state_t state, state_next;
    logic   in_set;
    logic   blink_clr, blink_end;
    logic   timeout;

    assign in_set = (state != RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= RUN;
        else        state <= state_next;
    end

    // NOTE: state_next gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        if (mode_vld) begin
            case (state)
                RUN:     state_next = HOUR;
                HOUR:    state_next = MIN;
                MIN:     state_next = SEC;
                default: state_next = RUN;
            endcase
        end else if (timeout && in_set) begin
            state_next = RUN;
        end
    end

    // Keep the field visible while it is being adjusted or just entered.
    assign blink_clr = !in_set || (state_next != state) || up_vld || down_vld;

    cyc_cnt #(.N(T_BLINK)) u_blink (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (blink_clr),
        .en      (in_set),
        .end_cnt (blink_end)
    );

`ifdef SET_CTRL_TIMEOUT_EN
    cyc_cnt #(.N(T_TIMEOUT)) u_idle (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!in_set || mode_vld || up_vld || down_vld),
        .en      (in_set),
        .end_cnt (timeout)
    );
`else
    // T_TIMEOUT only matters when the idle timer is built.
    logic unused_timeout_param;
    assign unused_timeout_param = (T_TIMEOUT > 0);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel    <= SEL_NONE;
            inc    <= 1'b0;
            dec    <= 1'b0;
            run_en <= 1'b1;
            show   <= 1'b1;
            done   <= 1'b0;
        end else begin
            sel    <= sel_of(state_next);
            run_en <= (state_next == RUN);
            inc    <= in_set && !mode_vld && up_vld && !down_vld;
            dec    <= in_set && !mode_vld && down_vld && !up_vld;
            done   <= in_set && (state_next == RUN);
            if (blink_clr)      show <= 1'b1;
            else if (blink_end) show <= ~show;
        end
    end

endmodule

// File: tb/tb_set_ctrl.sv
// Scoreboard bench for set_ctrl (T_BLINK=4, T_TIMEOUT=10); build with SET_CTRL_TIMEOUT_EN for timeout cases.
module tb_set_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode_vld = 1'b0;
    logic       up_vld = 1'b0;
    logic       down_vld = 1'b0;
    logic [2:0] sel;
    logic       inc, dec, run_en, show, done;

    always #5 clk = ~clk;

    set_ctrl #(.T_BLINK(4), .T_TIMEOUT(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode_vld (mode_vld),
        .up_vld   (up_vld),
        .down_vld (down_vld),
        .sel      (sel),
        .inc      (inc),
        .dec      (dec),
        .run_en   (run_en),
        .show     (show),
        .done     (done)
    );

    typedef struct packed {
        logic [2:0] sel;
        logic       inc;
        logic       dec;
        logic       run_en;
        logic       show;
        logic       done;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    checks   = 0;
    int    failures = 0;

    // Monitor: one expected observation per clock, compared mid-cycle.
    always @(negedge clk) begin
        obs_t  e;
        obs_t  a;
        string nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {sel, inc, dec, run_en, show, done};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL %s: got sel=%b inc=%b dec=%b run_en=%b show=%b done=%b, expected sel=%b inc=%b dec=%b run_en=%b show=%b done=%b",
                         nm, a.sel, a.inc, a.dec, a.run_en, a.show, a.done,
                         e.sel, e.inc, e.dec, e.run_en, e.show, e.done);
            end
        end
    end

    // Expected show after the i-th idle edge following a blink restart (T_BLINK = 4).
    function automatic logic bs(input int i);
        return ((i / 4) % 2) == 0;
    endfunction

    task automatic cyc(input logic r, input logic m, input logic u, input logic d,
                       input logic [2:0] s, input logic ei, input logic ed,
                       input logic esh, input logic edn, input string nm);
        obs_t e;
        rst_n    = r;
        mode_vld = m;
        up_vld   = u;
        down_vld = d;
        e = {s, ei, ed, (s == 3'b000), esh, edn};
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        mode_vld = 1'b0;
        up_vld   = 1'b0;
        down_vld = 1'b0;
    endtask

    task automatic idle(input int n, input logic [2:0] s, input int first_i, input string nm);
        for (int k = 0; k < n; k++) begin
            cyc(1, 0, 0, 0, s, 0, 0, bs(first_i + k), 0, nm);
        end
    endtask

    initial begin
        #1;
        // Reset state
        cyc(0, 0, 0, 0, 3'b000, 0, 0, 1, 0, "reset0");
        cyc(0, 1, 1, 0, 3'b000, 0, 0, 1, 0, "reset1");

        // Full mode cycle, 10 cycles apart
        cyc(1, 1, 0, 0, 3'b100, 0, 0, 1, 0, "mode_hour");
        idle(9, 3'b100, 1, "hour_idle");
        cyc(1, 1, 0, 0, 3'b010, 0, 0, 1, 0, "mode_min");
        idle(9, 3'b010, 1, "min_idle");
        cyc(1, 1, 0, 0, 3'b001, 0, 0, 1, 0, "mode_sec");
        idle(9, 3'b001, 1, "sec_idle");
        cyc(1, 1, 0, 0, 3'b000, 0, 0, 1, 1, "mode_run_done");
        cyc(1, 0, 0, 0, 3'b000, 0, 0, 1, 0, "run_done_drop");

        // Blink in MIN, restart on up
        cyc(1, 1, 0, 0, 3'b100, 0, 0, 1, 0, "hour_entry");
        cyc(1, 1, 0, 0, 3'b010, 0, 0, 1, 0, "min_entry");
        idle(5, 3'b010, 1, "min_blink");
        cyc(1, 0, 1, 0, 3'b010, 1, 0, 1, 0, "min_up_inc");
        idle(9, 3'b010, 1, "min_blink_restart");
        cyc(1, 1, 0, 0, 3'b001, 0, 0, 1, 0, "sec_entry");
        cyc(1, 1, 0, 0, 3'b000, 0, 0, 1, 1, "sec_exit_done");
        cyc(1, 1, 0, 0, 3'b100, 0, 0, 1, 0, "hour_entry2");

        // Simultaneous keys and back-to-back pulses in HOUR
        cyc(1, 0, 1, 1, 3'b100, 0, 0, 1, 0, "hour_updown");
        cyc(1, 0, 0, 1, 3'b100, 0, 1, 1, 0, "hour_down");
        cyc(1, 0, 1, 0, 3'b100, 1, 0, 1, 0, "hour_up_b2b1");
        cyc(1, 0, 1, 0, 3'b100, 1, 0, 1, 0, "hour_up_b2b2");
        cyc(1, 0, 0, 0, 3'b100, 0, 0, 1, 0, "hour_after");
        cyc(1, 1, 1, 0, 3'b010, 0, 0, 1, 0, "mode_up_prio");
        cyc(1, 1, 0, 1, 3'b001, 0, 0, 1, 0, "mode_down_prio");
        cyc(1, 1, 0, 0, 3'b000, 0, 0, 1, 1, "run_done2");

        // Keys ignored in RUN
        cyc(1, 0, 1, 0, 3'b000, 0, 0, 1, 0, "run_up_ignored");
        cyc(1, 0, 0, 1, 3'b000, 0, 0, 1, 0, "run_down_ignored");
        cyc(1, 0, 1, 1, 3'b000, 0, 0, 1, 0, "run_updown");

        // Idle in HOUR with a down press at idle cycle 8
        cyc(1, 1, 0, 0, 3'b100, 0, 0, 1, 0, "to_hour");
        idle(7, 3'b100, 1, "to_idle");
        cyc(1, 0, 0, 1, 3'b100, 0, 1, 1, 0, "to_down_restart");
        idle(9, 3'b100, 1, "to_idle2");
`ifdef SET_CTRL_TIMEOUT_EN
        cyc(1, 0, 0, 0, 3'b000, 0, 0, 1, 1, "timeout_done");
        cyc(1, 0, 0, 0, 3'b000, 0, 0, 1, 0, "after_timeout");
`else
        cyc(1, 0, 0, 0, 3'b100, 0, 0, bs(10), 0, "no_timeout");
        cyc(1, 1, 0, 0, 3'b010, 0, 0, 1, 0, "leave_min");
        cyc(1, 1, 0, 0, 3'b001, 0, 0, 1, 0, "leave_sec");
        cyc(1, 1, 0, 0, 3'b000, 0, 0, 1, 1, "leave_done");
        cyc(1, 0, 0, 0, 3'b000, 0, 0, 1, 0, "after_leave");
`endif

        // Reset while in SEC with show blanked
        cyc(1, 1, 0, 0, 3'b100, 0, 0, 1, 0, "rs_hour");
        cyc(1, 1, 0, 0, 3'b010, 0, 0, 1, 0, "rs_min");
        cyc(1, 1, 0, 0, 3'b001, 0, 0, 1, 0, "rs_sec");
        idle(5, 3'b001, 1, "rs_sec_idle");
        cyc(0, 0, 0, 0, 3'b000, 0, 0, 1, 0, "reset_in_sec");
        cyc(1, 0, 0, 0, 3'b000, 0, 0, 1, 0, "post_reset");

        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
